lmc_core: RTL and testbench

LMC_CORE -- requirements
Module: lmc_core

---
 rtl/lmc_core.sv | 86 ++++++++
 tb/tb_lmc_core.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lmc_core.sv
// lmc_core: Little Man Computer core with saturating decimal accumulator and INP/OUT handshakes.
module lmc_core #(
    parameter int MEM_DEPTH = 100
) (
    input  logic               clk,
    input  logic               reset,
    output logic [6:0]         mem_addr,
    output logic signed [10:0] mem_wdata,
    output logic               mem_we,
    input  logic signed [10:0] mem_rdata,
    input  logic signed [10:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [10:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               halted,
    output logic               error,
    output logic [6:0]         pc,
    output logic signed [10:0] acc
);
    typedef enum logic [2:0] {FETCH, EXEC, IN_WAIT, OUT_WAIT, HALT} state_t;
    state_t state, state_nx;
    logic signed [10:0] ir;
    logic [9:0] ir_u;
    logic [3:0] opcode;
    logic [6:0] operand;
    logic in_range, legal, exec, is_mem, take_branch;
    logic signed [11:0] sum;
    logic signed [10:0] sat_sum;
    assign in_range = !ir[10] && ir <= 11'sd999;
    assign ir_u     = in_range ? ir[9:0] : '0;
    assign opcode   = 4'(ir_u / 10'd100);
    assign operand  = 7'(ir_u % 10'd100);
    assign legal    = in_range && (ir_u == 10'd0 || ir_u == 10'd901 || ir_u == 10'd902 ||
                      opcode inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8});
    assign exec     = state == EXEC;
    assign is_mem   = exec && legal && opcode inside {4'd1, 4'd2, 4'd3, 4'd5};
    assign take_branch = opcode == 4'd6 || (opcode == 4'd7 && acc == 11'sd0) || (opcode == 4'd8 && !acc[10]);
    // 12-bit headroom covers every 11-bit sum/difference before clamping
    assign sum      = opcode == 4'd2 ? {acc[10], acc} - {mem_rdata[10], mem_rdata}
                                     : {acc[10], acc} + {mem_rdata[10], mem_rdata};
    assign sat_sum  = sum > 12'sd999 ? 11'sd999 : sum < -12'sd999 ? -11'sd999 : sum[10:0];
    assign mem_addr  = is_mem ? operand : pc;
    assign mem_wdata = acc;
    assign mem_we    = exec && legal && opcode == 4'd3;
    assign in_ready  = state == IN_WAIT;
    assign out_valid = state == OUT_WAIT;
    assign halted    = state == HALT;
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:    state_nx = EXEC;
            EXEC:     state_nx = (!legal || ir_u == 10'd0) ? HALT :
                                 ir_u == 10'd901 ? IN_WAIT :
                                 ir_u == 10'd902 ? OUT_WAIT : FETCH;
            IN_WAIT:  state_nx = in_valid ? FETCH : IN_WAIT;
            OUT_WAIT: state_nx = out_ready ? FETCH : OUT_WAIT;
            default:  state_nx = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            pc       <= '0;
            acc      <= '0;
            ir       <= '0;
            out_data <= '0;
            error    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FETCH) begin
                ir <= mem_rdata;
                pc <= pc == 7'(MEM_DEPTH - 1) ? '0 : pc + 7'd1;
            end
            if (exec && legal) begin
                if (opcode == 4'd1 || opcode == 4'd2) acc <= sat_sum;
                if (opcode == 4'd5) acc <= mem_rdata;
                if (take_branch) pc <= operand;
                if (ir_u == 10'd902) out_data <= acc;
            end
            if (exec && !legal) error <= 1'b1;
            if (state == IN_WAIT && in_valid) acc <= in_data;
        end
    end
endmodule

// File: tb/tb_lmc_core.sv
// tb_lmc_core: directed programs against lmc_core with a behavioural 100-word memory.
module tb_lmc_core;
    logic clk = 1'b0, reset = 1'b0;
    logic [6:0] mem_addr, pc;
    logic signed [10:0] mem_wdata, mem_rdata, in_data, out_data, acc;
    logic mem_we, in_valid, in_ready, out_valid, out_ready, halted, error;
    logic signed [10:0] mem [0:99];
    logic signed [10:0] img [0:99];
    logic load = 1'b0;
    int checks = 0, errors = 0;
    int outs, wes, overlap;
    logic signed [10:0] last_out, we_data;
    logic [6:0] we_addr;

    lmc_core dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted), .error(error), .pc(pc), .acc(acc)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem_addr < 7'd100 ? mem[mem_addr] : '0;
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 100; i++) mem[i] <= img[i];
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 100; i++) img[i] = '0;
    endtask

    task automatic boot();
        reset = 1'b0;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        outs = 0; wes = 0; overlap = 0;
    endtask

    task automatic run(input string tag, input int maxc);
        for (int c = 0; c < maxc && !halted; c++) begin
            @(negedge clk);
            if (out_valid) begin outs++; last_out = out_data; end
            if (mem_we) begin wes++; we_addr = mem_addr; we_data = mem_wdata; end
            if (in_ready && out_valid) overlap++;
        end
        check({tag, "_halted"}, 32'(halted), 1);
        check({tag, "_overlap"}, overlap, 0);
    endtask

    initial begin
        in_data = -11'sd5; in_valid = 1'b0; out_ready = 1'b1;
        clr();
        #2;
        check("rst_pc", 32'(pc), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_error", 32'(error), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_hs", 32'({in_ready, out_valid}), 0);
        // echo one input value back out
        img[0] = 11'sd901; img[1] = 11'sd902; img[2] = 11'sd0;
        in_valid = 1'b1;
        boot();
        run("io", 40);
        check("io_outs", outs, 1);
        check("io_data", 32'(last_out), -5);
        check("io_error", 32'(error), 0);
        check("io_pc", 32'(pc), 3);
        in_valid = 1'b0;
        clr();
        img[0] = 11'sd510; img[1] = 11'sd111; img[10] = 11'sd900; img[11] = 11'sd200;
        boot();
        run("satp", 40);
        check("satp_acc", 32'(acc), 999);
        img[1] = 11'sd211; img[10] = -11'sd900;
        boot();
        run("satn", 40);
        check("satn_acc", 32'(acc), -999);
        clr();
        img[0] = 11'sd510; img[1] = 11'sd350; img[10] = 11'sd123;
        boot();
        run("sta", 40);
        check("sta_count", wes, 1);
        check("sta_addr", 32'(we_addr), 50);
        check("sta_data", 32'(we_data), 123);
        check("sta_mem", 32'(mem[50]), 123);
        clr();
        img[0] = 11'sd720;
        boot();
        run("brz", 40);
        check("brz_pc", 32'(pc), 21);
        clr();
        img[0] = 11'sd510; img[1] = 11'sd830; img[10] = -11'sd1;
        boot();
        run("brpn", 40);
        check("brpn_pc", 32'(pc), 3);
        check("brpn_acc", 32'(acc), -1);
        clr();
        img[0] = 11'sd830;
        boot();
        run("brpz", 40);
        check("brpz_pc", 32'(pc), 31);
        // BRZ to 99, LDA there, wrap to 0 where BRZ now falls through
        clr();
        img[0] = 11'sd799; img[99] = 11'sd510; img[10] = 11'sd5;
        boot();
        run("wrap", 40);
        check("wrap_pc", 32'(pc), 2);
        check("wrap_acc", 32'(acc), 5);
        check("wrap_error", 32'(error), 0);
        clr();
        img[0] = 11'sd400;
        boot();
        run("ill4", 20);
        check("ill4_error", 32'(error), 1);
        check("ill4_we", wes, 0);
        repeat (3) @(negedge clk);
        check("ill4_pc_held", 32'(pc), 1);
        check("ill4_still_halted", 32'(halted), 1);
        img[0] = 11'sd905;
        boot();
        run("ill9", 20);
        check("ill9_error", 32'(error), 1);
        check("ill9_we", wes, 0);
        clr();
        img[0] = 11'sd0;
        boot();
        run("hlt", 20);
        check("hlt_error", 32'(error), 0);
        // reset while stalled in OUT_WAIT
        clr();
        img[0] = 11'sd510; img[1] = 11'sd902; img[10] = 11'sd42;
        out_ready = 1'b0;
        boot();
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
        check("ow_valid", 32'(out_valid), 1);
        repeat (5) @(negedge clk);
        check("ow_still_valid", 32'(out_valid), 1);
        check("ow_data", 32'(out_data), 42);
        reset = 1'b0;
        #1;
        check("ow_rst_valid", 32'(out_valid), 0);
        check("ow_rst_pc", 32'(pc), 0);
        check("ow_rst_acc", 32'(acc), 0);
        check("ow_rst_we", 32'(mem_we), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ow_rel_addr", 32'(mem_addr), 0);
        @(negedge clk);
        check("ow_rel_pc", 32'(pc), 1);
        out_ready = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
